// File: rtl/rpm_pkg.sv
// -----------------------------------------------------------------------------
// rpm_pkg
// Shared types and helpers for the Russian-peasant sequential multiplier.
//   state_t  : controller state encoding (IDLE, RUN, DONE), exposed for debug
//   MAX_W    : widest operand the magnitude helper can handle
//   prod_w() : product width for a given operand width
//   mag()    : absolute value of a w-bit (optionally signed) value
// -----------------------------------------------------------------------------
package rpm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int MAX_W = 64;

    function automatic int prod_w(input int w);
        return 2 * w;
    endfunction

    // Magnitude of the low w bits of v. When sgn is set those bits are taken
    // as two's complement. -2^(w-1) maps to 2^(w-1), which still fits in w
    // unsigned bits, so the result never overflows.
    function automatic logic [MAX_W-1:0] mag(input logic [MAX_W-1:0] v,
                                             input int unsigned     w,
                                             input logic            sgn);
        logic [MAX_W-1:0] mask;
        logic [MAX_W-1:0] r;
        mask = {MAX_W{1'b1}} >> (MAX_W - w);
        r    = v & mask;
        if (sgn && v[w-1]) begin
            r = (~r + MAX_W'(1)) & mask;
        end
        return r;
    endfunction

endpackage

// File: rtl/rpm_mult_seq_ctrl.sv
// -----------------------------------------------------------------------------
// rpm_ctrl
// Controller FSM for the shift-and-add multiplier.
// Handshake: start is a request sampled only while IDLE; requests in RUN or
// DONE are dropped, never queued. done is a single-cycle pulse in DONE and
// marks the product as valid.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   start    : operation request (IDLE only)
//   x_zero   : datapath iteration register has reached zero
//   load     : capture operands this edge
//   step     : perform one shift/add iteration this edge
//   finish   : write the (sign-corrected) product this edge
//   busy     : high in RUN and DONE
//   done     : high in DONE
//   state    : current state, for debug/checkers
// -----------------------------------------------------------------------------
module rpm_ctrl
    import rpm_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   start,
    input  logic   x_zero,
    output logic   load,
    output logic   step,
    output logic   finish,
    output logic   busy,
    output logic   done,
    output state_t state
);

    state_t state_q;
    state_t state_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        finish  = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                // Early termination: stop as soon as the multiplier runs dry.
                if (x_zero) begin
                    finish  = 1'b1;
                    state_d = DONE;
                end else begin
                    step = 1'b1;
                end
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign state = state_q;

endmodule

// File: rtl/rpm_mult_seq.sv
// -----------------------------------------------------------------------------
// rpm_mult_seq
// Sequential Russian-peasant multiplier with early termination. The operand of
// smaller magnitude drives the iteration count, so latency tracks its bit
// length rather than WIDTH. Signed operands are multiplied as magnitudes and
// the sign is applied once at the end.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   start       : request, sampled only in IDLE
//   signed_mode : a, b are two's complement (ignored when SIGNED_EN = 0)
//   a, b        : WIDTH-bit operands, captured with start
//   busy        : high in RUN and DONE
//   done        : one-cycle pulse, product valid
//   product     : 2*WIDTH-bit result, held until the next operation completes
// -----------------------------------------------------------------------------
module rpm_mult_seq
    import rpm_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int SIGNED_EN = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int PW = prod_w(WIDTH);

    logic [WIDTH-1:0] x_q;
    logic [PW-1:0]    y_q;
    logic [PW-1:0]    acc_q;
    logic             sign_q;

    logic             load;
    logic             step;
    logic             finish;
    state_t           dbg_state;

    // Operand conditioning (only used on the load edge).
    logic             sgn_op;
    logic [MAX_W-1:0] a_mag_w;
    logic [MAX_W-1:0] b_mag_w;
    logic [WIDTH-1:0] ma;
    logic [WIDTH-1:0] mb;
    logic             a_small;

    assign sgn_op  = signed_mode && (SIGNED_EN != 0);
    assign a_mag_w = mag({{(MAX_W-WIDTH){1'b0}}, a}, WIDTH, sgn_op);
    assign b_mag_w = mag({{(MAX_W-WIDTH){1'b0}}, b}, WIDTH, sgn_op);
    assign ma      = a_mag_w[WIDTH-1:0];
    assign mb      = b_mag_w[WIDTH-1:0];
    assign a_small = (ma < mb);

    rpm_ctrl u_ctrl (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .x_zero (x_q == '0),
        .load   (load),
        .step   (step),
        .finish (finish),
        .busy   (busy),
        .done   (done),
        .state  (dbg_state)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q     <= '0;
            y_q     <= '0;
            acc_q   <= '0;
            sign_q  <= 1'b0;
            product <= '0;
        end else if (load) begin
            x_q    <= a_small ? ma : mb;
            y_q    <= {{WIDTH{1'b0}}, (a_small ? mb : ma)};
            acc_q  <= '0;
            sign_q <= sgn_op & (a[WIDTH-1] ^ b[WIDTH-1]);
        end else if (step) begin
            if (x_q[0]) begin
                acc_q <= acc_q + y_q;
            end
            x_q <= x_q >> 1;
            y_q <= y_q << 1;
        end else if (finish) begin
            // Negating zero yields zero, so a signed zero product stays 0.
            product <= sign_q ? (PW'(0) - acc_q) : acc_q;
        end
    end

endmodule

// File: doc/rpm_mult_seq.md
Name: rpm_mult_seq

Overview:
Parametrised sequential Russian-peasant (shift-and-add) multiplier. It integrates the controller FSM and datapath into one block with a start/done handshake and optional two's-complement operands.
- Successor features: early termination, plus operand swap so the smaller magnitude drives the iteration count.
- Sits as a multi-cycle arithmetic unit behind a simple command interface.

Parameters:
WIDTH, 8, operand width in bits (>=2); product is 2*WIDTH bits.
SIGNED_EN, 1, 1 = honour signed_mode input; 0 = signed_mode ignored (unsigned only, sign logic removed).

Ports:
clk  in  1  rising-edge clock
rst  in  1  reset; asynchronous and active-high
start  in  1  request; sampled only in IDLE
signed_mode  in  1  1 = a,b are two's complement; sampled with start
a  in  WIDTH  multiplicand
b  in  WIDTH  multiplier
busy  out  1  high in RUN and DONE
done  out  1  one-cycle pulse; product valid
product  out  2*WIDTH  result; held until the next accepted start completes

Behaviour:
- Reset (async, rst=1): state=IDLE, busy=0, done=0, product=0, internal x/y/acc/sign=0. Reset mid-operation aborts with no done pulse.
- States: IDLE, RUN, DONE (enum in package).
- IDLE, start=1 at edge E0:
  - ma=|a|, mb=|b| (absolute value only if signed_mode&SIGNED_EN, else raw).
  - sign=a[MSB]^b[MSB] if signed, else 0.
  - x=min(ma,mb) (WIDTH bits); y=max(ma,mb) zero-extended to 2*WIDTH; acc=0.
  - Next state RUN.
  - Tie ma==mb: either choice is acceptable; result is identical.
- IDLE, start=0: hold; product unchanged.
- RUN, x!=0: if x[0] then acc<=acc+y (mod 2^(2W)); x<=x>>1; y<=y<<1 (bits shifted out dropped).
- RUN, x==0 (early termination): product<=sign ? -acc : acc (2W-bit two's complement); next DONE.
- DONE: done=1 for exactly this cycle, busy=1; next IDLE unconditionally.
- Latency: let k = bit length of min(ma,mb) (k=0 when either operand is 0).
  - done is high in the cycle after edge E(k+1).
  - Minimum 1 edge; maximum WIDTH+1 edges (k=WIDTH, e.g. unsigned 255*255 or signed -128*-128 at W=8).
  - Next start is accepted at the first edge where state is IDLE, i.e. 1 cycle after done.
- start asserted in RUN or DONE is ignored (not queued). Operand changes after E0 have no effect.
- Magnitude of -2^(W-1) is 2^(W-1); it fits in WIDTH unsigned bits, so no overflow. Max signed product magnitude 2^(2W-2) fits in 2W bits.
- Zero operand: x=0 immediately; product=0 (never -0); done after E1.
- Signed result with acc=0 and sign=1: product must be 0.
- No combinational path from inputs to outputs; all outputs are registered or state-decoded.

Decomposition:
- Package rpm_pkg:
  - state_t enum {IDLE, RUN, DONE}, 2-bit.
  - Function for magnitude/abs on a WIDTH-bit value.
  - Localparam helpers PW=2*WIDTH.
- Sub-module rpm_ctrl: FSM taking start, x_zero; producing load, step, finish, busy, done.
- The datapath (x/y/acc registers, swap, negate) stays in rpm_mult_seq.

Test Plan:
1. W=8 unsigned, a=13, b=11, start one cycle -> x=11 (k=4); done after E5; product=16'd143; busy high E1..E5.
2. W=8 signed, a=-7 (8'hF9), b=6 -> x=6 (k=3); done after E4; product=16'hFFD6 (-42).
3. W=8 signed, a=b=8'h80 (-128) -> k=8; done after E9; product=16'h4000. Unsigned a=b=255 -> done after E9; product=16'hFE01.
4. a=0, b=200 unsigned and signed a=0, b=-5 -> done after E1; product=0 in both cases.
5. Start a=13, b=11; re-pulse start with a=2, b=2 during RUN -> ignored; product=143. Then a new start in IDLE with 2*2 -> product=4; product holds 143 until that done.
6. Assert rst asynchronously mid-RUN (between edges) -> busy, done, product go 0 immediately; no done pulse. A fresh start after release computes correctly.
